// File: rtl/lbist_pkg.sv
// Shared types and constants for the LBIST response compactor.
package lbist_pkg;

  localparam int          LBIST_SIGW      = 32;
  localparam logic [31:0] LBIST_MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] LBIST_MISR_SEED = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } lbist_misr_st_e;

endpackage

// File: rtl/lbist_misr_cmp_if.sv
// Run-control, scan-data and status bundle between the LBIST controller and the compactor.
interface lbist_misr_cmp_if #(
  parameter int SCW = 8
);
  logic            lbist_start;
  logic [15:0]     cfg_lbist_pat;
  logic [15:0]     cfg_chain_depth;
  logic [31:0]     cfg_golden_sig;
  logic            shift_vld;
  logic [SCW-1:0]  scan_out;
  logic            lbist_busy;
  logic            lbist_done;
  logic            lbist_pass;
  logic [31:0]     lbist_sig;
  logic [15:0]     pat_cnt;

  modport master (
    output lbist_start, cfg_lbist_pat, cfg_chain_depth, cfg_golden_sig, shift_vld, scan_out,
    input  lbist_busy, lbist_done, lbist_pass, lbist_sig, pat_cnt
  );

  modport slave (
    input  lbist_start, cfg_lbist_pat, cfg_chain_depth, cfg_golden_sig, shift_vld, scan_out,
    output lbist_busy, lbist_done, lbist_pass, lbist_sig, pat_cnt
  );
endinterface

// File: rtl/lbist_misr.sv
// 32-bit multiple-input signature register with seed load and enable.
module lbist_misr
  import lbist_pkg::*;
#(
  parameter int                    SCW  = 8,
  parameter logic [LBIST_SIGW-1:0] POLY = LBIST_MISR_POLY,
  parameter logic [LBIST_SIGW-1:0] SEED = LBIST_MISR_SEED
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  en,
  input  logic [SCW-1:0]        din,
  output logic [LBIST_SIGW-1:0] sig,
  output logic [LBIST_SIGW-1:0] sig_nxt
);

  // Value the register takes if enabled this cycle; exported so the compare
  // can see the final signature on the same edge it is captured.
  always_comb begin
    sig_nxt = {sig[LBIST_SIGW-2:0], 1'b0}
            ^ (sig[LBIST_SIGW-1] ? POLY : '0)
            ^ LBIST_SIGW'(din);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge mclk) begin
    if (!rst_n || clr) begin
      sig <= '0;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/lbist_misr_cmp.sv
// LBIST response compactor: run FSM, shift/pattern counters and golden compare around the MISR.
module lbist_misr_cmp
  import lbist_pkg::*;
#(
  parameter int                    SCW  = 8,
  parameter int                    SIGW = LBIST_SIGW,
  parameter logic [LBIST_SIGW-1:0] POLY = LBIST_MISR_POLY,
  parameter logic [LBIST_SIGW-1:0] SEED = LBIST_MISR_SEED
) (
  input  logic                 mclk,
  input  logic                 rst_n,
  input  logic                 srst,
  lbist_misr_cmp_if.slave      bus
);

  lbist_misr_st_e  state, state_nxt;
  logic [15:0]     shift_cnt, shift_nxt;
  logic [15:0]     pat_q, pat_nxt;
  logic            busy_q, busy_nxt;
  logic            done_q, done_nxt;
  logic            pass_q, pass_nxt;
  logic            misr_load, misr_en;
  logic [15:0]     shift_last;
  logic [SIGW-1:0] sig, sig_nxt;

  lbist_misr #(
    .SCW  (SCW),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .mclk    (mclk),
    .rst_n   (rst_n),
    .clr     (srst),
    .load    (misr_load),
    .en      (misr_en),
    .din     (bus.scan_out),
    .sig     (sig),
    .sig_nxt (sig_nxt)
  );

  // A chain depth of 0 behaves like a single shift per pattern.
  assign shift_last = (bus.cfg_chain_depth == 16'd0) ? 16'd0 : bus.cfg_chain_depth - 16'd1;

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_cnt;
    pat_nxt   = pat_q;
    done_nxt  = done_q;
    pass_nxt  = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (bus.lbist_start) begin
          misr_load = 1'b1;
          shift_nxt = '0;
          pat_nxt   = '0;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          if (bus.cfg_lbist_pat == 16'd0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            pass_nxt  = (SEED == bus.cfg_golden_sig);
          end else begin
            state_nxt = COMPACT;
          end
        end
      end

      COMPACT: begin
        if (bus.shift_vld) begin
          misr_en = 1'b1;
          if (shift_cnt == shift_last) begin
            shift_nxt = '0;
            pat_nxt   = pat_q + 16'd1;
            // Compare against the signature being written on this edge.
            if (pat_nxt == bus.cfg_lbist_pat) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
              pass_nxt  = (sig_nxt == bus.cfg_golden_sig);
            end
          end else begin
            shift_nxt = shift_cnt + 16'd1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == COMPACT);
  end

  always_ff @(posedge mclk) begin
    if (!rst_n || srst) begin
      state     <= IDLE;
      shift_cnt <= '0;
      pat_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_cnt <= shift_nxt;
      pat_q     <= pat_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      pass_q    <= pass_nxt;
    end
  end

  assign bus.lbist_busy = busy_q;
  assign bus.lbist_done = done_q;
  assign bus.lbist_pass = pass_q;
  assign bus.lbist_sig  = sig;
  assign bus.pat_cnt    = pat_q;

endmodule

// File: tb/tb_lbist_misr_cmp.sv
// Self-checking bench for lbist_misr_cmp: table-driven runs with a signature scoreboard plus abort/zero-config sequences.
module tb_lbist_misr_cmp;

  localparam int          SCW  = 8;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;

  logic mclk = 1'b0;
  logic rst_n;
  logic srst;

  lbist_misr_cmp_if #(.SCW(SCW)) bus ();

  lbist_misr_cmp #(.SCW(SCW)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .srst  (srst),
    .bus   (bus)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [15:0] depth;
    logic [15:0] pat;
    logic [7:0]  salt;
    bit          gap;      // insert capture cycles between shifts
    bit          poke;     // pulse lbist_start mid-run (must be ignored)
    bit          use_model;
    logic [31:0] exp_sig;  // used when use_model = 0
    logic [31:0] golden;   // literal golden, or XOR mask on the model signature
  } vec_t;

  typedef struct {
    logic [31:0] sig;
    logic        pass;
    logic [15:0] pat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge mclk);
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [7:0] d);
    logic [31:0] r;
    r = s << 1;
    if (s[31]) r = r ^ POLY;
    return r ^ {24'd0, d};
  endfunction

  function automatic logic [7:0] data_at(input logic [7:0] salt, input int i);
    return salt + 8'(i * 59);
  endfunction

  task automatic wait_done(input string tag);
    int n = 0;
    exp_t e;
    while (!bus.lbist_done && n < 50) begin
      step();
      n++;
    end
    check({tag, "_done"}, {31'd0, bus.lbist_done}, 32'd1);
    check({tag, "_latency"}, n, 0);
    check({tag, "_busy_low"}, {31'd0, bus.lbist_busy}, 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sig"}, bus.lbist_sig, e.sig);
      check({tag, "_pass"}, {31'd0, bus.lbist_pass}, {31'd0, e.pass});
      check({tag, "_pat_cnt"}, {16'd0, bus.pat_cnt}, {16'd0, e.pat});
    end else begin
      check({tag, "_scoreboard_empty"}, sb.size(), 1);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          shifts;
    logic [31:0] m;
    logic [31:0] exp_sig;
    logic [31:0] golden;
    exp_t        e;
    shifts = int'(v.pat) * ((v.depth == 16'd0) ? 1 : int'(v.depth));
    m = SEED;
    for (int i = 0; i < shifts; i++) m = ref_step(m, data_at(v.salt, i));
    exp_sig = v.use_model ? m : v.exp_sig;
    golden  = v.use_model ? (m ^ v.golden) : v.golden;

    bus.cfg_chain_depth = v.depth;
    bus.cfg_lbist_pat   = v.pat;
    bus.cfg_golden_sig  = golden;
    bus.shift_vld       = 1'b0;
    bus.lbist_start     = 1'b1;
    step();
    bus.lbist_start = 1'b0;
    check({tag, "_start_done_clr"}, {31'd0, bus.lbist_done}, 32'd0);
    check({tag, "_start_seed"}, bus.lbist_sig, SEED);
    check({tag, "_start_busy"}, {31'd0, bus.lbist_busy}, 32'd1);

    for (int i = 0; i < shifts; i++) begin
      if (v.gap && (i % 3 == 1)) begin
        bus.shift_vld   = 1'b0;
        bus.scan_out    = 8'hFF;
        bus.lbist_start = v.poke;
        step();
      end
      bus.shift_vld   = 1'b1;
      bus.scan_out    = data_at(v.salt, i);
      bus.lbist_start = v.poke && (i == 1);
      if (i == shifts - 1) begin
        check({tag, "_not_early"}, {31'd0, bus.lbist_done}, 32'd0);
        e.sig  = exp_sig;
        e.pass = (golden == exp_sig);
        e.pat  = v.pat;
        sb.push_back(e);
      end
      step();
    end
    bus.shift_vld   = 1'b0;
    bus.lbist_start = 1'b0;
    wait_done(tag);
  endtask

  task automatic abort_run(input bit use_srst, input string tag);
    bus.cfg_chain_depth = 16'd4;
    bus.cfg_lbist_pat   = 16'd3;
    bus.cfg_golden_sig  = 32'h0;
    bus.lbist_start     = 1'b1;
    step();
    bus.lbist_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.shift_vld = 1'b1;
      bus.scan_out  = 8'(i + 3);
      step();
    end
    bus.shift_vld = 1'b0;
    if (use_srst) srst = 1'b1;
    else          rst_n = 1'b0;
    step();
    check({tag, "_sig"}, bus.lbist_sig, 32'h0);
    check({tag, "_flags"}, {29'd0, bus.lbist_busy, bus.lbist_done, bus.lbist_pass}, 32'd0);
    check({tag, "_pat_cnt"}, {16'd0, bus.pat_cnt}, 32'd0);
    srst  = 1'b0;
    rst_n = 1'b1;
    step();
    check({tag, "_stays_idle"}, {30'd0, bus.lbist_busy, bus.lbist_done}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'd1, 16'd1, 8'hA5, 1'b0, 1'b0, 1'b0, 32'hFB3E_E2EC, 32'hFB3E_E2EC};
    vecs[1] = '{16'd1, 16'd1, 8'hA5, 1'b0, 1'b0, 1'b0, 32'hFB3E_E2EC, 32'h0000_0000};
    vecs[2] = '{16'd4, 16'd3, 8'h11, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[3] = '{16'd0, 16'd2, 8'h5C, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1};
    vecs[4] = '{16'd3, 16'd4, 8'hC3, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0};
    vecs[5] = '{16'd5, 16'd2, 8'h7E, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0};

    rst_n               = 1'b0;
    srst                = 1'b0;
    bus.lbist_start     = 1'b0;
    bus.cfg_lbist_pat   = 16'd0;
    bus.cfg_chain_depth = 16'd0;
    bus.cfg_golden_sig  = 32'd0;
    bus.shift_vld       = 1'b0;
    bus.scan_out        = '0;
    step();
    step();
    check("reset_sig", bus.lbist_sig, 32'h0);
    check("reset_flags", {29'd0, bus.lbist_busy, bus.lbist_done, bus.lbist_pass}, 32'd0);
    check("reset_pat_cnt", {16'd0, bus.pat_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Zero patterns: done one cycle after start with the seed as signature.
    bus.cfg_lbist_pat   = 16'd0;
    bus.cfg_chain_depth = 16'd4;
    bus.cfg_golden_sig  = SEED;
    bus.lbist_start     = 1'b1;
    step();
    bus.lbist_start = 1'b0;
    check("pat0_done", {31'd0, bus.lbist_done}, 32'd1);
    check("pat0_sig", bus.lbist_sig, SEED);
    check("pat0_pass", {31'd0, bus.lbist_pass}, 32'd1);
    check("pat0_busy", {31'd0, bus.lbist_busy}, 32'd0);
    step();
    check("pat0_hold", {31'd0, bus.lbist_done}, 32'd1);

    abort_run(1'b0, "abort_rstn");
    run_vec(vecs[2], "after_rstn");
    abort_run(1'b1, "abort_srst");
    run_vec(vecs[4], "after_srst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
